// File: rtl/writeback_stage.sv
// writeback_stage: registers MEM results, aligns loads and drives the register-file write port
module writeback_stage #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              Stall,
  input  logic              Flush,
  input  logic              in_valid,
  input  logic              in_RegWrite,
  input  logic              in_MemToReg,
  input  logic              in_Link,
  input  logic [2:0]        in_LoadType,
  input  logic [1:0]        in_ByteOff,
  input  logic [ADDR_W-1:0] in_Rd,
  input  logic [DATA_W-1:0] in_AluResult,
  input  logic [DATA_W-1:0] in_MemData,
  input  logic [DATA_W-1:0] in_PCPlus8,
  output logic              RegWr,
  output logic [ADDR_W-1:0] RW,
  output logic [DATA_W-1:0] BusW,
  output logic              wb_valid,
  output logic              exc_misalign,
  output logic [31:0]       retired_count
);
  logic [7:0] ldByte;
  logic [15:0] ldHalf;
  logic [DATA_W-1:0] loadData, result;
  logic isHalf, isWord, mis, regWriteQ, misQ, written;
  // big-endian sub-word extraction, result select and misalignment detection
  always_comb begin
    ldByte = 8'(in_MemData >> {~in_ByteOff, 3'b000});
    ldHalf = in_ByteOff[1] ? in_MemData[15:0] : in_MemData[31:16];
    isHalf = in_LoadType == 3'b011 || in_LoadType == 3'b100;
    isWord = in_LoadType == 3'b000 || in_LoadType > 3'b100;
    loadData = in_LoadType == 3'b001 ? {{24{ldByte[7]}}, ldByte} :
               in_LoadType == 3'b010 ? {24'b0, ldByte} :
               in_LoadType == 3'b011 ? {{16{ldHalf[15]}}, ldHalf} :
               in_LoadType == 3'b100 ? {16'b0, ldHalf} : in_MemData;
    result = in_Link ? in_PCPlus8 : in_MemToReg ? loadData : in_AluResult;
    mis = in_valid & in_MemToReg & (isHalf ? in_ByteOff[0] : isWord & (in_ByteOff != 2'b00));
  end
  // WB register: reset, then flush, then stall hold, else capture
  always_ff @(posedge Clk) begin
    if (Rst) begin
      wb_valid <= 1'b0;
      regWriteQ <= 1'b0;
      RW <= '0;
      BusW <= '0;
      misQ <= 1'b0;
      written <= 1'b0;
      retired_count <= '0;
    end else if (Flush) begin
      wb_valid <= 1'b0;
      regWriteQ <= 1'b0;
      misQ <= 1'b0;
      written <= 1'b0;
    end else if (Stall) begin
      written <= 1'b1;
    end else begin
      wb_valid <= in_valid;
      regWriteQ <= in_RegWrite;
      RW <= in_Rd;
      BusW <= result;
      misQ <= mis;
      written <= 1'b0;
      retired_count <= retired_count + 32'(in_valid);
    end
  end
  // a held instruction writes and raises its exception only in its first WB cycle
  always_comb begin
    RegWr = wb_valid & regWriteQ & (RW != '0) & ~misQ & ~written;
    exc_misalign = wb_valid & misQ & ~written;
  end
endmodule

// File: tb/tb_writeback_stage.sv
// tb_writeback_stage: directed stimulus checked against a behavioural writeback model
module tb_writeback_stage;
  logic Clk = 0, Rst = 1, Stall = 0, Flush = 0;
  logic valid = 0, regWrite = 0, memToReg = 0, link = 0;
  logic [2:0] loadType = 0;
  logic [1:0] byteOff = 0;
  logic [4:0] rd = 0;
  logic [31:0] alu = 0, memData = 0, pc8 = 0;
  logic RegWr, wbValid, exc;
  logic [4:0] RW;
  logic [31:0] BusW, retired;
  int errors = 0, checks = 0;

  writeback_stage dut (
    .Clk(Clk), .Rst(Rst), .Stall(Stall), .Flush(Flush),
    .in_valid(valid), .in_RegWrite(regWrite), .in_MemToReg(memToReg), .in_Link(link),
    .in_LoadType(loadType), .in_ByteOff(byteOff), .in_Rd(rd),
    .in_AluResult(alu), .in_MemData(memData), .in_PCPlus8(pc8),
    .RegWr(RegWr), .RW(RW), .BusW(BusW), .wb_valid(wbValid),
    .exc_misalign(exc), .retired_count(retired)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // model state: what the instruction in WB is and whether its first cycle has passed
  bit mValid, mFresh, mWe, mMis, mKnown;
  logic [4:0] mRd;
  logic [31:0] mData, mCount;

  function automatic logic [31:0] modelLoad(input logic [2:0] t, input logic [1:0] o, input logic [31:0] w);
    int b, h;
    b = int'((w / (32'd1 << (8 * (3 - int'(o))))) % 256);
    h = o[1] ? int'(w % 65536) : int'(w / 65536);
    case (t)
      3'd1: return 32'(b >= 128 ? b - 256 : b);
      3'd2: return 32'(b);
      3'd3: return 32'(h >= 32768 ? h - 65536 : h);
      3'd4: return 32'(h);
      default: return w;
    endcase
  endfunction

  function automatic bit modelMis(input logic [2:0] t, input logic [1:0] o);
    if (t == 3'd3 || t == 3'd4) return o % 2 == 1;
    if (t == 3'd1 || t == 3'd2) return 0;
    return o != 0;
  endfunction

  always @(posedge Clk) begin
    if (Rst) begin
      mValid = 0; mFresh = 0; mWe = 0; mMis = 0; mKnown = 1; mRd = 0; mData = 0; mCount = 0;
    end else if (Flush) begin
      mValid = 0; mKnown = 0;
    end else if (Stall) begin
      mFresh = 0;
    end else begin
      mValid = valid; mFresh = 1; mWe = regWrite; mRd = rd; mKnown = 1;
      mData = link ? pc8 : memToReg ? modelLoad(loadType, byteOff, memData) : alu;
      mMis = valid && memToReg && modelMis(loadType, byteOff);
      if (valid) mCount = mCount + 1;
    end
  end

  always @(negedge Clk) begin
    chk("RegWr", 32'(RegWr), 32'(mValid && mFresh && mWe && mRd != 0 && !mMis));
    chk("wb_valid", 32'(wbValid), 32'(mValid));
    chk("exc_misalign", 32'(exc), 32'(mValid && mFresh && mMis));
    chk("retired_count", retired, mCount);
    if (mKnown) begin
      chk("RW", 32'(RW), 32'(mRd));
      chk("BusW", BusW, mData);
    end
  end

  task automatic drive(input bit v, input bit we, input bit m2r, input bit lk, input logic [2:0] t,
                       input logic [1:0] o, input logic [4:0] d, input logic [31:0] a);
    @(negedge Clk);
    valid = v; regWrite = we; memToReg = m2r; link = lk; loadType = t; byteOff = o; rd = d; alu = a;
    @(posedge Clk);
    #1;
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    memData = 32'h80FF7F01;
    pc8 = 32'h00000400;
    repeat (2) idle();
    chk("rst RegWr", 32'(RegWr), 0);
    chk("rst RW", 32'(RW), 0);
    chk("rst BusW", BusW, 0);
    chk("rst count", retired, 0);
    chk("rst wb_valid", 32'(wbValid), 0);
    @(negedge Clk) Rst = 0;
    drive(1, 1, 0, 0, 0, 0, 5, 32'h12345678);
    chk("alu RegWr", 32'(RegWr), 1);
    chk("alu RW", 32'(RW), 5);
    chk("alu BusW", BusW, 32'h12345678);
    chk("alu count", retired, 1);
    drive(1, 1, 1, 0, 3'd1, 2'd0, 3, 0);
    chk("lb0", BusW, 32'hFFFFFF80);
    drive(1, 1, 1, 0, 3'd2, 2'd1, 3, 0);
    chk("lbu1", BusW, 32'h000000FF);
    drive(1, 1, 1, 0, 3'd3, 2'd2, 3, 0);
    chk("lh2", BusW, 32'h00007F01);
    drive(1, 1, 1, 0, 3'd4, 2'd0, 3, 0);
    chk("lhu0", BusW, 32'h000080FF);
    drive(1, 1, 1, 0, 3'd3, 2'd1, 3, 0);
    chk("lh1 exc", 32'(exc), 1);
    chk("lh1 RegWr", 32'(RegWr), 0);
    chk("lh1 count", retired, 6);
    idle();
    chk("exc pulse", 32'(exc), 0);
    drive(1, 1, 1, 0, 3'd0, 2'd2, 3, 0);
    chk("lw2 exc", 32'(exc), 1);
    chk("lw2 count", retired, 7);
    drive(1, 1, 0, 0, 0, 0, 7, 32'hAAAA5555);
    chk("stall first", 32'(RegWr), 1);
    @(negedge Clk) Stall = 1;
    drive(1, 1, 0, 0, 0, 0, 9, 32'h11111111);
    drive(1, 1, 0, 0, 0, 0, 9, 32'h11111111);
    chk("stall held RegWr", 32'(RegWr), 0);
    chk("stall held RW", 32'(RW), 7);
    chk("stall count", retired, 8);
    Flush = 1;
    drive(1, 1, 0, 0, 0, 0, 9, 32'h11111111);
    chk("flush RegWr", 32'(RegWr), 0);
    chk("flush valid", 32'(wbValid), 0);
    chk("flush count", retired, 8);
    @(negedge Clk) begin Flush = 0; Stall = 0; end
    drive(1, 1, 0, 1, 0, 0, 0, 32'h22222222);
    chk("rd0 RegWr", 32'(RegWr), 0);
    chk("rd0 BusW", BusW, 32'h00000400);
    #1;
    force dut.retired_count = 32'hFFFFFFFF;
    mCount = 32'hFFFFFFFF;
    #1;
    release dut.retired_count;
    drive(1, 1, 0, 0, 0, 0, 6, 32'h33333333);
    chk("wrap", retired, 0);
    drive(1, 1, 0, 0, 0, 0, 4, 32'h44444444);
    @(negedge Clk) begin Stall = 1; Rst = 1; end
    @(posedge Clk) #1;
    chk("rst stall RegWr", 32'(RegWr), 0);
    chk("rst stall valid", 32'(wbValid), 0);
    @(negedge Clk) begin Stall = 0; Rst = 0; end
    repeat (2) idle();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
